pipeline_ctrl: RTL and testbench

//  Parametrised pipeline control unit. Replaces the fixed 6-stage stall generator.

---
 rtl/pipeline_ctrl_pkg.sv | 25 ++
 rtl/pipeline_ctrl_wdog.sv | 42 ++++
 rtl/pipeline_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, FSM state type and sizing helper for the pipeline control unit.
// Optional feature macro used by the top: PIPE_PERF_CNT_EN.
package pipeline_ctrl_pkg;

   localparam logic RST_ENABLE = 1'b1;
   localparam logic STOP       = 1'b1;

   typedef enum logic {
      PC_RUN   = 1'b0,
      PC_FLUSH = 1'b1
   } pc_state_e;

   localparam int unsigned STG_PC  = 0;
   localparam int unsigned STG_IF  = 1;
   localparam int unsigned STG_ID  = 2;
   localparam int unsigned STG_EX  = 3;
   localparam int unsigned STG_MEM = 4;
   localparam int unsigned STG_WB  = 5;

   // Width needed to hold 0..limit, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/pipeline_ctrl_wdog.sv
// Stuck-stall watchdog: saturating consecutive-stall counter and sticky timeout flag.
// LIMIT = 0 disables the flag entirely.
module stall_wdog
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned LIMIT = 64,
   parameter int unsigned CNT_W = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_any_i,
   output logic timeout_o
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             timeout_q;

   always_comb begin
      wcnt_d = '0;
      if (stall_any_i) begin
         wcnt_d = (wcnt_q == LIM) ? LIM : wcnt_q + 1'b1;
      end
   end

   // Flag follows the count reaching the limit on the same edge.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         wcnt_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         if ((LIMIT != 0) && (wcnt_d == LIM)) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_o = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: thermometer stall mask, flush sequencer with redirect PC, watchdog.
// Define PIPE_PERF_CNT_EN to build the stalled-cycle and flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES   = 6,
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned WDOG_LIMIT   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_STAGES-1:0] stallreq,
   input  logic                  flush_req,
   input  logic [ADDR_W-1:0]     flush_target,
   output logic [NUM_STAGES-1:0] stall,
   output logic                  flush,
   output logic [ADDR_W-1:0]     new_pc,
   output logic                  wdog_timeout,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_flush
);

   localparam int unsigned FC_W = cnt_width(FLUSH_CYCLES);
   localparam int unsigned WD_W = cnt_width(WDOG_LIMIT);

   pc_state_e             state_q;
   logic                  flush_q;
   logic [ADDR_W-1:0]     new_pc_q;
   logic [FC_W-1:0]       cnt_q;
   logic [NUM_STAGES-1:0] stall_mask;

   // A stage holds when it or any later stage requests; squashed stages are ignored.
   always_comb begin
      stall_mask = '0;
      if ((rst != RST_ENABLE) && (state_q == PC_RUN)) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (|(stallreq >> k)) begin
               stall_mask[k] = STOP;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q  <= PC_RUN;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            PC_RUN: begin
               if (flush_req) begin
                  state_q  <= PC_FLUSH;
                  flush_q  <= 1'b1;
                  new_pc_q <= flush_target;
                  cnt_q    <= FC_W'(FLUSH_CYCLES - 1);
               end
            end
            PC_FLUSH: begin
               if (cnt_q == '0) begin
                  state_q  <= PC_RUN;
                  flush_q  <= 1'b0;
                  new_pc_q <= '0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= PC_RUN;
               flush_q <= 1'b0;
            end
         endcase
      end
   end

   stall_wdog #(
      .LIMIT (WDOG_LIMIT),
      .CNT_W (WD_W)
   ) u_wdog (
      .clk         (clk),
      .rst         (rst),
      .stall_any_i (|stall_mask),
      .timeout_o   (wdog_timeout)
   );

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (|stall_mask) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if ((state_q == PC_RUN) && flush_req) begin
            perf_flush_q <= perf_flush_q + 32'd1;
         end
      end
   end

   assign perf_stall = perf_stall_q;
   assign perf_flush = perf_flush_q;
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
`endif

   assign stall  = stall_mask;
   assign flush  = flush_q;
   assign new_pc = new_pc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised bench for pipeline_ctrl against a cycle-level behavioural model.
// Honours PIPE_PERF_CNT_EN the same way as the design build.
module tb_pipeline_ctrl;

   localparam int NS = 6;
   localparam int AW = 32;
   localparam int FC = 3;
   localparam int WL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] stallreq;
   logic          flush_req;
   logic [AW-1:0] flush_target;
   logic [NS-1:0] stall;
   logic          flush;
   logic [AW-1:0] new_pc;
   logic          wdog_timeout;
   logic [31:0]   perf_stall;
   logic [31:0]   perf_flush;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .NUM_STAGES   (NS),
      .ADDR_W       (AW),
      .FLUSH_CYCLES (FC),
      .WDOG_LIMIT   (WL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq     (stallreq),
      .flush_req    (flush_req),
      .flush_target (flush_target),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .wdog_timeout (wdog_timeout),
      .perf_stall   (perf_stall),
      .perf_flush   (perf_flush)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: flush cycles still to show, redirect PC, stall run length, flags, counters.
   int          rem    = 0;
   logic [AW-1:0] m_pc = '0;
   int          m_wcnt = 0;
   logic        m_to   = 1'b0;
   logic [31:0] m_ps   = '0;
   logic [31:0] m_pf   = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [NS-1:0] exp_mask(input logic [NS-1:0] req);
      int h = -1;
      logic [63:0] ones;
      for (int i = 0; i < NS; i++) if (req[i]) h = i;
      if (h < 0) return '0;
      ones = (64'd1 << (h + 1)) - 64'd1;
      return ones[NS-1:0];
   endfunction

   task automatic cycle(input logic r, input logic [NS-1:0] sr, input logic fr,
                        input logic [AW-1:0] tg);
      logic [NS-1:0] es;
      @(negedge clk);
      rst          = r;
      stallreq     = sr;
      flush_req    = fr;
      flush_target = tg;
      #1;
      es = (r || rem > 0) ? '0 : exp_mask(sr);
      check_eq("stall", 64'(stall), 64'(es));
      @(posedge clk);
      if (r) begin
         rem = 0; m_pc = '0; m_wcnt = 0; m_to = 1'b0; m_ps = '0; m_pf = '0;
      end else begin
         if (es != '0) begin
            m_ps   = m_ps + 32'd1;
            m_wcnt = (m_wcnt < WL) ? m_wcnt + 1 : WL;
         end else begin
            m_wcnt = 0;
         end
         if (WL != 0 && m_wcnt == WL) m_to = 1'b1;
         if (rem > 0) begin
            rem--;
            if (rem == 0) m_pc = '0;
         end else if (fr) begin
            rem  = FC;
            m_pc = tg;
            m_pf = m_pf + 32'd1;
         end
      end
      #1;
      check_eq("flush", 64'(flush), 64'(rem > 0));
      check_eq("new_pc", 64'(new_pc), 64'(m_pc));
      check_eq("wdog_timeout", 64'(wdog_timeout), 64'(m_to));
`ifdef PIPE_PERF_CNT_EN
      check_eq("perf_stall", 64'(perf_stall), 64'(m_ps));
      check_eq("perf_flush", 64'(perf_flush), 64'(m_pf));
`else
      check_eq("perf_stall", 64'(perf_stall), 64'd0);
      check_eq("perf_flush", 64'(perf_flush), 64'd0);
`endif
   endtask

   initial begin
      rst = 1'b1; stallreq = '0; flush_req = 1'b0; flush_target = '0;

      cycle(1'b1, '1, 1'b0, '0);
      cycle(1'b1, '1, 1'b1, 32'h1234);

      cycle(1'b0, 6'b000100, 1'b0, '0);
      cycle(1'b0, 6'b001100, 1'b0, '0);
      cycle(1'b0, 6'b000000, 1'b0, '0);

      cycle(1'b0, 6'b111111, 1'b1, 32'h0000_0020);
      cycle(1'b0, 6'b111111, 1'b0, '0);
      cycle(1'b0, 6'b111111, 1'b1, 32'h0000_0040);
      cycle(1'b0, 6'b111111, 1'b0, '0);
      cycle(1'b0, 6'b000000, 1'b0, '0);
      cycle(1'b0, 6'b000000, 1'b0, '0);

      cycle(1'b1, '0, 1'b0, '0);
      repeat (6) cycle(1'b0, 6'b000010, 1'b0, '0);
      repeat (3) cycle(1'b0, 6'b000000, 1'b0, '0);
      cycle(1'b1, '0, 1'b0, '0);
      cycle(1'b0, '0, 1'b0, '0);

      cycle(1'b0, 6'b000001, 1'b1, 32'h0000_ABCD);
      cycle(1'b1, '1, 1'b0, '0);
      cycle(1'b0, '0, 1'b0, '0);

      for (int n = 0; n < 3000; n++) begin
         logic          r;
         logic [NS-1:0] sr;
         logic          fr;
         logic [AW-1:0] tg;
         r  = ($urandom_range(0, 99) == 0) || (n % 250 == 0);
         sr = ($urandom_range(0, 9) < 4) ? '0 : NS'($urandom);
         fr = ($urandom_range(0, 7) == 0);
         tg = $urandom;
         cycle(r, sr, fr, tg);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
